uart_rx_word_buffer: RTL and testbench
======================================

UART_RX_WORD_BUFFER -- requirements
Module: uart_rx_word_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, byte capacity of the receive ring; power of two, 4..65536.
REQ-002 SHALL have parameter WORD_BYTES, default 4, bytes packed per delivered word; 1..4.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, gather-stall limit (used only under REQ-031).
REQ-004 SHALL have port clk  input  1  single system clock, rising edge.
REQ-005 SHALL have port rstn  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port rx_data  input  8  byte from UART receiver.
REQ-007 SHALL have port rx_valid  input  1  receiver valid level; may stay high for several cycles per byte.
REQ-008 SHALL have port word_req  input  1  core request for one word; sampled only in IDLE.
REQ-009 SHALL have port word_data  output  8*WORD_BYTES  assembled word, little-endian.
REQ-010 SHALL have port word_valid  output  1  one-cycle pulse, word_data valid.
REQ-011 SHALL have port busy  output  1  high in GATHER and DONE.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  bytes stored.
REQ-013 SHALL have port overflow  output  1  sticky, set when a byte is dropped.
REQ-014 SHALL have port clear_ovf  input  1  synchronous clear of overflow.
REQ-015 SHALL have port timed_out  output  1  qualifies word_valid; constant 0 when REQ-031 is off.

Function
REQ-016 SHALL capture a byte only on the first cycle rx_valid is high after being low; an edge detector registers the previous level.
REQ-017 SHALL write the captured byte at wr_ptr and increment wr_ptr and count when the registered count < DEPTH; wr_ptr wraps from DEPTH-1 to 0.
REQ-018 SHALL drop the byte and set overflow when count == DEPTH at capture, even if a pop occurs in the same cycle.
REQ-019 SHALL hold overflow until clear_ovf or reset; if a drop and clear_ovf coincide, overflow stays 1.
REQ-020 SHALL implement states IDLE, GATHER, DONE; IDLE -> GATHER on word_req, clearing the lane index and word_data.
REQ-021 SHALL, in GATHER, pop one byte per cycle while count > 0 into lane = lane index; the first byte goes to bits [7:0].
REQ-022 SHALL not pop a byte in the cycle it is written; a byte pushed into an empty ring is poppable on the next cycle.
REQ-023 SHALL update count as +1 for push only, -1 for pop only, and unchanged for simultaneous push and pop.
REQ-024 SHALL move GATHER -> DONE in the cycle after the WORD_BYTES-th pop; word_valid = 1 in DONE for exactly one cycle; DONE -> IDLE unconditionally.
REQ-025 SHALL hold word_data stable from DONE until the next IDLE -> GATHER transition.
REQ-026 SHALL ignore word_req outside IDLE; no queuing of requests.
REQ-027 SHALL give latency word_req -> word_valid of WORD_BYTES+2 cycles when the ring holds at least WORD_BYTES bytes.

Reset
REQ-028 SHALL, on rstn low, asynchronously force: state IDLE, wr_ptr = rd_ptr = count = 0, word_data = 0, word_valid = 0, busy = 0, overflow = 0, timed_out = 0, edge-detect register = 0.
REQ-029 SHALL discard any partial word and all stored bytes when reset asserts mid-GATHER; ring RAM contents need not be cleared.
REQ-030 SHALL not capture a byte while rx_valid is already high at reset release until rx_valid returns low and rises again.

Configuration
REQ-031 SHALL, with macro UART_RX_WORD_BUFFER_TIMEOUT_EN defined, count consecutive GATHER cycles with count == 0; on reaching TIMEOUT_CYCLES, go to DONE with unfilled lanes 0 and timed_out = 1 for the word_valid cycle; any pop resets the counter.
REQ-032 SHALL, without the macro, contain no timeout counter, keep GATHER waiting indefinitely, and tie timed_out to 0.

Verification
REQ-033 SHALL cover: WORD_BYTES=4; bytes 0x78,0x56,0x34,0x12, each with rx_valid high 3 cycles; then word_req -> word_valid after 6 cycles, word_data = 0x12345678, count = 0.
REQ-034 SHALL cover: word_req with an empty ring, then one byte every 10 cycles -> busy = 1 throughout, a single word_valid 2 cycles after the 4th push, no pop in any push cycle.
REQ-035 SHALL cover: DEPTH=4; push 5 bytes 0x01..0x05 -> count = 4, overflow = 1, next word = 0x04030201; clear_ovf -> overflow = 0.
REQ-036 SHALL cover: DEPTH=4; 12 bytes streamed with 3 interleaved word_req -> wr_ptr and rd_ptr each wrap, words 0x04030201, 0x08070605, 0x0C0B0A09, no overflow.
REQ-037 SHALL cover: rstn low after 2 of 4 pops -> all outputs at reset values; a fresh 4-byte sequence afterwards returns the correct word.
REQ-038 SHALL cover: macro defined, TIMEOUT_CYCLES=16; 2 bytes 0xBB,0xAA then word_req -> word_valid with word_data = 0x0000AABB and timed_out = 1 after 16 empty cycles.

Source files
------------

// File: rtl/uart_rx_word_buffer.sv
// uart_rx_word_buffer
// Buffers bytes from a UART receiver in a power-of-two ring. On a core
// request it gathers WORD_BYTES bytes into one little-endian word and
// delivers it with a one-cycle word_valid pulse.
// The gather-stall timeout is built only when UART_RX_WORD_BUFFER_TIMEOUT_EN
// is defined. With the timeout, a stalled gather delivers a partial word that
// is flagged with timed_out. Without it, GATHER waits forever and timed_out
// is tied low.
module uart_rx_word_buffer #(
  parameter int DEPTH          = 4096,
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    word_req,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    clear_ovf,
  output logic                    timed_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(WORD_BYTES + 1);
  localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  // Parameter sanity, caught at elaboration
  if (DEPTH < 4 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_word_buffer: DEPTH must be a power of two in 4..65536");
  end
  if (WORD_BYTES < 1 || WORD_BYTES > 4) begin : g_bad_word_bytes
    $error("uart_rx_word_buffer: WORD_BYTES must be in 1..4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_rx_word_buffer: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    DONE
  } state_t;

  state_t         state_reg;
  logic [PW-1:0]  pop_cnt_reg;
  logic           word_valid_reg;
  logic           busy_reg;

  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           overflow_reg;

  logic           rx_prev_reg;
  logic           rx_armed_reg;

  logic [7:0]     mem [DEPTH];
  logic [7:0]     rd_data_reg;
  logic           lane_pend_reg;
  logic [LW-1:0]  lane_idx_reg;

  logic           capture;
  logic           ring_full;
  logic           push;
  logic           drop;
  logic           pop;
  logic           start;
  logic           all_popped;

  // The previous rx_valid level gives a rising-edge detector. rx_armed_reg
  // blocks a capture when rx_valid is already high at reset release, until
  // rx_valid has been seen low once.
  assign capture    = rx_valid & ~rx_prev_reg & rx_armed_reg;
  assign ring_full  = (count_reg == CW'(DEPTH));
  assign push       = capture & ~ring_full;
  assign drop       = capture & ring_full;
  assign all_popped = (pop_cnt_reg == PW'(WORD_BYTES));
  // The pop uses the registered count. A byte written this cycle is therefore
  // never popped in the same cycle.
  assign pop        = (state_reg == GATHER) && !all_popped && (count_reg != '0);
  assign start      = (state_reg == IDLE) && word_req;

`ifdef UART_RX_WORD_BUFFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0]  stall_cnt_reg;
  logic           timed_out_reg;
  logic           stall_expire;

  // This empty GATHER cycle is the TIMEOUT_CYCLES-th one in a row
  assign stall_expire = (count_reg == '0) && (stall_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
  assign timed_out    = timed_out_reg;
`else
  assign timed_out = 1'b0;
`endif

  // Edge detector on the receiver valid level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_prev_reg  <= 1'b0;
      rx_armed_reg <= 1'b0;
    end else begin
      rx_prev_reg <= rx_valid;
      if (!rx_valid) begin
        rx_armed_reg <= 1'b1;
      end
    end
  end

  // Ring pointers and occupancy; a push and a pop in the same cycle cancel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as clear_ovf leaves it set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (clear_ovf) begin
      overflow_reg <= 1'b0;
    end
  end

  // Ring storage: one write port and a registered read of the head byte.
  // The read address is never the address being written. A pop needs
  // count > 0, and a write only happens when the ring is not full.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= rx_data;
    end
    if (pop) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Remember which lane the byte being read out belongs to
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_pend_reg <= 1'b0;
      lane_idx_reg  <= '0;
    end else begin
      lane_pend_reg <= pop;
      lane_idx_reg  <= pop_cnt_reg[LW-1:0];
    end
  end

  // Word assembly. Each lane clears when a new word starts and loads the
  // byte that was popped for it. It then holds until the next word starts.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [7:0] lane_reg;

      // Per-lane clear on word start, load on its own pop
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          lane_reg <= '0;
        end else if (start) begin
          lane_reg <= '0;
        end else if (lane_pend_reg && (lane_idx_reg == LW'(gi))) begin
          lane_reg <= rd_data_reg;
        end
      end

      assign word_data[8*gi +: 8] = lane_reg;
    end
  endgenerate

  // Request FSM with registered word_valid, busy and timed_out. The last
  // lane load lands on the same edge as GATHER -> DONE, so word_data is
  // complete while word_valid is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      pop_cnt_reg    <= '0;
      word_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef UART_RX_WORD_BUFFER_TIMEOUT_EN
      stall_cnt_reg  <= '0;
      timed_out_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          word_valid_reg <= 1'b0;
          if (word_req) begin
            state_reg   <= GATHER;
            busy_reg    <= 1'b1;
            pop_cnt_reg <= '0;
`ifdef UART_RX_WORD_BUFFER_TIMEOUT_EN
            stall_cnt_reg <= '0;
`endif
          end
        end
        GATHER: begin
          if (all_popped) begin
            state_reg      <= DONE;
            word_valid_reg <= 1'b1;
          end else if (pop) begin
            pop_cnt_reg <= pop_cnt_reg + PW'(1);
`ifdef UART_RX_WORD_BUFFER_TIMEOUT_EN
            stall_cnt_reg <= '0;
          end else if (stall_expire) begin
            state_reg      <= DONE;
            word_valid_reg <= 1'b1;
            timed_out_reg  <= 1'b1;
          end else begin
            stall_cnt_reg <= stall_cnt_reg + TW'(1);
`endif
          end
        end
        DONE: begin
          state_reg      <= IDLE;
          word_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
`ifdef UART_RX_WORD_BUFFER_TIMEOUT_EN
          timed_out_reg  <= 1'b0;
`endif
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign word_valid = word_valid_reg;
  assign busy       = busy_reg;
  assign count      = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_uart_rx_word_buffer.sv
`timescale 1ns/1ps
// Bench for uart_rx_word_buffer: directed scenarios, a queue-based model
// checked every cycle, and literal expectations per scenario.
module tb_uart_rx_word_buffer;
  localparam int DEPTH = 4;
  localparam int WB    = 4;
  localparam int TO    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_WORD_BUFFER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic word_req = 1'b0;
  logic clear_ovf = 1'b0;
  logic [8*WB-1:0] word_data;
  logic word_valid, busy, overflow, timed_out;
  logic [CW-1:0] count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_push_drv = 0;
  int req_drv = 0;

  always #5 clk = ~clk;

  uart_rx_word_buffer #(
    .DEPTH(DEPTH), .WORD_BYTES(WB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .word_req(word_req), .word_data(word_data), .word_valid(word_valid),
    .busy(busy), .count(count), .overflow(overflow), .clear_ovf(clear_ovf),
    .timed_out(timed_out)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A byte queue plus "a word is being gathered / was just delivered".
  logic [7:0]      q[$];
  bit              m_gather, m_done, m_ovf, m_prev, m_valid, m_to, m_cap;
  int              m_npop, m_stall, m_size0;
  logic [8*WB-1:0] m_got, m_word;

  task automatic m_finish(input bit to);
    m_gather = 1'b0;
    m_done   = 1'b1;
    m_valid  = 1'b1;
    m_to     = to;
    m_word   = m_got;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      q.delete();
      m_gather = 0; m_done = 0; m_ovf = 0; m_valid = 0; m_to = 0;
      m_prev = 1'b1;   // a level already high at release is not a new byte
      m_npop = 0; m_stall = 0; m_got = '0; m_word = '0;
    end else begin
      m_size0 = q.size();
      m_cap   = rx_valid && !m_prev;
      m_prev  = rx_valid;
      m_valid = 1'b0;
      m_to    = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_gather) begin
        if (m_npop == WB) begin
          m_finish(1'b0);
        end else if (m_size0 > 0) begin
          m_got[8*m_npop +: 8] = q.pop_front();
          m_npop++;
          m_stall = 0;
        end else begin
          m_stall++;
          if (TO_EN && m_stall == TO) m_finish(1'b1);
        end
      end else if (word_req) begin
        m_gather = 1'b1; m_npop = 0; m_got = '0; m_stall = 0;
      end
      if (m_cap) begin
        if (m_size0 == DEPTH) m_ovf = 1'b1;
        else q.push_back(rx_data);
      end
      if (clear_ovf && !(m_cap && m_size0 == DEPTH)) m_ovf = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] obs_w[$];
  int          obs_cyc[$];
  bit          obs_to[$];

  always @(posedge clk) begin
    #1;
    check("word_valid", {31'd0, word_valid}, {31'd0, m_valid});
    check("busy", {31'd0, busy}, {31'd0, (m_gather || m_done)});
    check("count", 32'(count), 32'(q.size()));
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("timed_out", {31'd0, timed_out}, {31'd0, m_to});
    if (m_valid || !rstn) check("word_data", 32'(word_data), 32'(m_valid ? m_word : '0));
    if (word_valid === 1'b1) begin
      obs_w.push_back(32'(word_data));
      obs_cyc.push_back(cyc);
      obs_to.push_back(timed_out);
    end
  end

  // ---------------- stimulus helpers (enter and leave on a negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data = b;
    rx_valid = 1'b1;
    last_push_drv = cyc;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic req_word();
    int n0;
    n0 = obs_w.size();
    word_req = 1'b1;
    req_drv = cyc;
    @(negedge clk);
    word_req = 1'b0;
    for (int i = 0; i < 300 && obs_w.size() == n0; i++) @(negedge clk);
    total++;
    if (obs_w.size() == n0) begin
      bad++;
      $display("FAIL word_arrival: got no word_valid want one within 300 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200 us");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_word_data", 32'(word_data), 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    rstn = 1'b1;
    tick(2);

    // Four bytes held 3 cycles each, then one request
    send_byte(8'h78, 3, 2); send_byte(8'h56, 3, 2);
    send_byte(8'h34, 3, 2); send_byte(8'h12, 3, 2);
    check("s1_count_before", 32'(count), 32'd4);
    req_word();
    check("s1_word", obs_w[$], 32'h12345678);
    check("s1_model_word", 32'(m_word), 32'h12345678);
    check("s1_latency", 32'(obs_cyc[$] - req_drv), 32'd6);
    check("s1_timed_out", {31'd0, obs_to[$]}, 32'd0);
    check("s1_count_after", 32'(count), 32'd0);
    tick(2);

    // Request on an empty ring, then one byte every 10 cycles
    fork
      req_word();
      begin
        tick(2);
        send_byte(8'hA1, 2, 8); send_byte(8'hA2, 2, 8);
        send_byte(8'hA3, 2, 8); send_byte(8'hA4, 2, 8);
      end
    join
    check("s2_word", obs_w[$], 32'hA4A3A2A1);
    check("s2_push_to_valid", 32'(obs_cyc[$] - last_push_drv), 32'd3);
    check("s2_count", 32'(count), 32'd0);
    tick(2);

    // Overflow: five bytes into a 4-deep ring; the drop coincides with clear_ovf
    for (int b = 1; b <= 4; b++) send_byte(8'(b), 2, 2);
    check("s3_full_count", 32'(count), 32'd4);
    check("s3_no_ovf_yet", {31'd0, overflow}, 32'd0);
    rx_data = 8'h05; rx_valid = 1'b1; clear_ovf = 1'b1;
    @(negedge clk); clear_ovf = 1'b0;
    @(negedge clk); rx_valid = 1'b0;
    tick(2);
    check("s3_ovf_set", {31'd0, overflow}, 32'd1);
    check("s3_count_kept", 32'(count), 32'd4);
    req_word();
    check("s3_word", obs_w[$], 32'h04030201);
    check("s3_ovf_sticky", {31'd0, overflow}, 32'd1);
    clear_ovf = 1'b1;
    @(negedge clk); clear_ovf = 1'b0;
    tick(1);
    check("s3_ovf_cleared", {31'd0, overflow}, 32'd0);

    // Twelve bytes streamed with three interleaved requests; both pointers wrap
    for (int b = 1; b <= 4; b++) send_byte(8'(b), 2, 2);
    fork
      req_word();
      begin tick(2); for (int b = 5; b <= 8; b++) send_byte(8'(b), 2, 2); end
    join
    check("s4_word1", obs_w[$], 32'h04030201);
    fork
      req_word();
      begin tick(2); for (int b = 9; b <= 12; b++) send_byte(8'(b), 2, 2); end
    join
    check("s4_word2", obs_w[$], 32'h08070605);
    req_word();
    check("s4_word3", obs_w[$], 32'h0C0B0A09);
    check("s4_no_ovf", {31'd0, overflow}, 32'd0);
    check("s4_count", 32'(count), 32'd0);
    tick(2);

    // Reset after two of four pops, rx_valid high across the release
    for (int b = 0; b < 4; b++) send_byte(8'h11 + 8'(b), 2, 2);
    word_req = 1'b1;
    @(negedge clk); word_req = 1'b0;
    tick(2);
    rstn = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h99;
    #1;
    check("s5_rst_word_data", 32'(word_data), 32'h0);
    check("s5_rst_valid", {31'd0, word_valid}, 32'd0);
    check("s5_rst_busy", {31'd0, busy}, 32'd0);
    check("s5_rst_count", 32'(count), 32'd0);
    check("s5_rst_timed_out", {31'd0, timed_out}, 32'd0);
    tick(2);
    rstn = 1'b1;
    tick(3);
    check("s5_no_capture_high_at_release", 32'(count), 32'd0);
    rx_valid = 1'b0;
    tick(1);
    for (int b = 0; b < 4; b++) send_byte(8'h21 + 8'(b), 2, 2);
    req_word();
    check("s5_word", obs_w[$], 32'h24232221);
    tick(2);

`ifdef UART_RX_WORD_BUFFER_TIMEOUT_EN
    // Partial word after 16 empty gather cycles
    send_byte(8'hBB, 2, 2); send_byte(8'hAA, 2, 2);
    req_word();
    check("s6_word", obs_w[$], 32'h0000AABB);
    check("s6_timed_out", {31'd0, obs_to[$]}, 32'd1);
    check("s6_latency", 32'(obs_cyc[$] - req_drv), 32'd19);
    tick(2);
`endif

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
